bmi_calc_seq: RTL and testbench

BMI_CALC_SEQ -- requirements
Module: bmi_calc_seq

---
 rtl/bmi_calc_seq.sv | 124 ++++++++++++
 tb/tb_bmi_calc_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bmi_calc_seq.sv
// Sequential BMI calculator: result = weight*10000/height^2 as R_INT.FRAC fixed point,
// computed by a bit-serial restoring divider and followed by a WHO-style category.
module bmi_calc_seq #(
    parameter int W_WIDTH = 8,
    parameter int H_WIDTH = 8,
    parameter int FRAC    = 8,
    parameter int R_INT   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [W_WIDTH-1:0]       weight,
    input  logic [H_WIDTH-1:0]       height,
    output logic                     busy,
    output logic                     done,
    output logic [R_INT+FRAC-1:0]    result,
    output logic [2:0]               category,
    output logic                     err
);
    localparam int Q     = R_INT + FRAC;
    localparam int N_W   = W_WIDTH + 14 + FRAC;
    localparam int D_W   = 2 * H_WIDTH;
    localparam int CMP_W = N_W + D_W;
    localparam int C_W   = $clog2(Q + 1);

    // 18.5 is compared as 37/2 against a doubled result so the threshold stays exact for any FRAC
    localparam logic [Q:0] T18_5X2 = (Q+1)'(37 * (2 ** FRAC));
    localparam logic [Q:0] T25     = (Q+1)'(25 * (2 ** FRAC));
    localparam logic [Q:0] T30     = (Q+1)'(30 * (2 ** FRAC));

    typedef enum logic [2:0] {IDLE, LOAD, DIV, CLASS, DONE} state_t;

    state_t             state;
    logic [W_WIDTH-1:0] w_r;
    logic [H_WIDTH-1:0] h_r;
    logic [D_W-1:0]     den;
    logic [D_W-1:0]     rem;
    logic [Q-1:0]       quo;
    logic [C_W-1:0]     cnt;
    logic               ovf;

    logic [N_W-1:0]     num;
    logic [D_W-1:0]     den_c;
    logic [D_W:0]       trial;

    function automatic logic [2:0] classify(input logic [Q-1:0] r);
        logic [Q:0] r1;
        logic [Q:0] r2;
        r1 = {1'b0, r};
        r2 = {r, 1'b0};
        if (r2 < T18_5X2)  return 3'd0;
        else if (r1 < T25) return 3'd1;
        else if (r1 < T30) return 3'd2;
        else               return 3'd3;
    endfunction

    always_comb begin
        num   = (N_W'(w_r) * N_W'(14'd10000)) << FRAC;
        den_c = D_W'(h_r) * D_W'(h_r);
        trial = {rem, quo[Q-1]};
    end

    // quo doubles as the low dividend bits and the quotient shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            category <= '0;
            err      <= 1'b0;
            w_r      <= '0;
            h_r      <= '0;
            den      <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w_r   <= weight;
                        h_r   <= height;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    den   <= den_c;
                    rem   <= D_W'(num >> Q);
                    quo   <= num[Q-1:0];
                    cnt   <= C_W'(Q);
                    ovf   <= (den_c == '0) || (CMP_W'(num >> Q) >= CMP_W'(den_c));
                    state <= DIV;
                end
                DIV: begin
                    if (trial >= {1'b0, den}) begin
                        rem <= D_W'(trial - {1'b0, den});
                        quo <= {quo[Q-2:0], 1'b1};
                    end else begin
                        rem <= trial[D_W-1:0];
                        quo <= {quo[Q-2:0], 1'b0};
                    end
                    cnt <= cnt - C_W'(1);
                    if (cnt == C_W'(1)) state <= CLASS;
                end
                CLASS: begin
                    result   <= ovf ? '1 : quo;
                    category <= ovf ? 3'd7 : classify(quo);
                    err      <= ovf;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bmi_calc_seq.sv
// Self-checking bench for bmi_calc_seq: directed vectors, random vectors against a
// plain-arithmetic model, busy/start handling, back-to-back spacing and mid-operation reset.
module tb_bmi_calc_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  weight;
    logic [7:0]  height;
    logic        busy;
    logic        done;
    logic [23:0] result;
    logic [2:0]  category;
    logic        err;

    int checks = 0;
    int failures = 0;

    bmi_calc_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .weight   (weight),
        .height   (height),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .category (category),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // BMI = kg*10000/cm^2 scaled by 2^8, truncated; anything not fitting 24 bits is an error
    task automatic model(input int w, input int h, output logic [23:0] r,
                         output logic [2:0] c, output logic e);
        longint n, d, q;
        n = longint'(w) * 10000 * 256;
        d = longint'(h) * h;
        if (d == 0 || (n / d) > 64'hFFFFFF) begin
            r = 24'hFFFFFF; c = 3'd7; e = 1'b1;
        end else begin
            q = n / d;
            r = q[23:0];
            e = 1'b0;
            if (q * 2 < 37 * 256)   c = 3'd0;
            else if (q < 25 * 256)  c = 3'd1;
            else if (q < 30 * 256)  c = 3'd2;
            else                    c = 3'd3;
        end
    endtask

    task automatic run_op(input int w, input int h, input string tag);
        logic [23:0] er;
        logic [2:0]  ec;
        logic        ee;
        int          lat;
        model(w, h, er, ec, ee);
        @(negedge clk);
        weight = 8'(w); height = 8'(h); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        weight = 8'($urandom);
        height = 8'($urandom);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd26);
        chk({tag, "_res"}, 32'(result), 32'(er));
        chk({tag, "_cat"}, 32'(category), 32'(ec));
        chk({tag, "_err"}, 32'(err), 32'(ee));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
        chk({tag, "_hold"}, 32'(result), 32'(er));
    endtask

    initial begin
        int t1, t2, ndone, k, w, h;
        rst_n = 1'b0; start = 1'b0; weight = '0; height = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {busy, done, err, category, result}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op(80, 170, "d80_170");
        chk("d80_170_lit", {5'd0, category, result}, {5'd0, 3'd2, 24'h001BAE});
        run_op(70, 175, "d70_175");
        chk("d70_175_lit", {5'd0, category, result}, {5'd0, 3'd1, 24'h0016DB});
        run_op(50, 180, "d50_180");
        chk("d50_180_lit", {5'd0, category, result}, {5'd0, 3'd0, 24'h000F6E});
        run_op(25, 100, "d25_100");
        chk("d25_100_lit", {5'd0, category, result}, {5'd0, 3'd2, 24'h001900});
        run_op(70, 0, "h0");
        chk("h0_lit", {4'd0, err, category, result}, {4'd0, 1'b1, 3'd7, 24'hFFFFFF});
        run_op(255, 1, "w255_h1");
        chk("w255_h1_lit", {4'd0, err, category, result}, {4'd0, 1'b1, 3'd7, 24'hFFFFFF});

        for (int i = 0; i < 16; i++) begin
            w = int'($urandom_range(0, 255));
            h = (i < 4) ? int'($urandom_range(0, 12)) : int'($urandom_range(100, 255));
            run_op(w, h, "rand");
        end

        // start pulses during a busy operation must not queue a second one
        ndone = 0;
        @(negedge clk); weight = 8'd80; height = 8'd170; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk); start = (i == 5 || i == 20);
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        start = 1'b0;
        chk("busy_ignore_ndone", 32'(ndone), 32'd1);
        chk("busy_ignore_idle", 32'(busy), 32'd0);

        // held start: accept edge is k=1, done pulses are 28 edges apart
        t1 = 0; t2 = 0;
        @(negedge clk); weight = 8'd80; height = 8'd170; start = 1'b1;
        for (k = 1; k <= 80 && t2 == 0; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (t1 == 0) t1 = k;
                else begin t2 = k; start = 1'b0; end
            end
        end
        start = 1'b0;
        chk("b2b_first", 32'(t1), 32'd27);
        chk("b2b_gap", 32'(t2 - t1), 32'd28);
        chk("b2b_res", 32'(result), 32'h001BAE);
        repeat (2) @(posedge clk);

        // reset in the middle of the divide aborts with no done pulse
        @(negedge clk); weight = 8'd80; height = 8'd170; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (11) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        chk("midrst_outs", {busy, done, err, category, result}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        chk("midrst_nodone", 32'(ndone), 32'd0);
        run_op(80, 170, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
